// File: rtl/mem_bus_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_pkg
//   Shared definitions for the Tick-strobed memory bus. The MEMORY bench model
//   uses the same latency constant, so the master and its responder agree on
//   when read data is valid.
//
//   Contents
//     MEM_BUS_ADDR_W   default address width (16)
//     MEM_BUS_DATA_W   default data width (8)
//     MEM_BUS_LATENCY  wait cycles between the Tick cycle and the capture cycle
//     mem_bus_state_e  master FSM states IDLE / ISSUE / WAIT / CAP
//     cnt_width()      width of a counter that holds 0..n-1 (at least 1 bit)
// ----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int MEM_BUS_ADDR_W  = 16;
    localparam int MEM_BUS_DATA_W  = 8;
    localparam int MEM_BUS_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CAP   = 2'd3
    } mem_bus_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// ----------------------------------------------------------------------------
// mem_bus_master_if
//   Bundles the requester handshake and the MEMORY-side strobe bus of the
//   memory bus master. Clock and reset are not part of the bundle.
//
//   Requester side : ReqValid, ReqReady, ReqAddr, ReqWE, ReqData,
//                    ReqWord (only with MEM_BUS_WORD_EN), RspValid, RspData
//   MEMORY side    : MemAddress, MemDataOut, MemWE, MemOE, MemTick, MemDataIn
//
//   Modports
//     master : the bus master (drives ReqReady, Rsp*, Mem* except MemDataIn)
//     slave  : the surrounding environment (requester + MEMORY)
//
//   Configuration macro: MEM_BUS_WORD_EN adds the ReqWord signal.
// ----------------------------------------------------------------------------
interface mem_bus_master_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = MEM_BUS_ADDR_W,
    parameter int DATA_W = MEM_BUS_DATA_W
);

    logic                  ReqValid;
    logic                  ReqReady;
    logic [ADDR_W-1:0]     ReqAddr;
    logic                  ReqWE;
    logic [DATA_W-1:0]     ReqData;
`ifdef MEM_BUS_WORD_EN
    logic                  ReqWord;
`endif
    logic                  RspValid;
    logic [2*DATA_W-1:0]   RspData;

    logic [ADDR_W-1:0]     MemAddress;
    logic [DATA_W-1:0]     MemDataOut;
    logic                  MemWE;
    logic                  MemOE;
    logic                  MemTick;
    logic [DATA_W-1:0]     MemDataIn;

    modport master (
`ifdef MEM_BUS_WORD_EN
        input  ReqWord,
`endif
        input  ReqValid,
        output ReqReady,
        input  ReqAddr,
        input  ReqWE,
        input  ReqData,
        output RspValid,
        output RspData,
        output MemAddress,
        output MemDataOut,
        output MemWE,
        output MemOE,
        output MemTick,
        input  MemDataIn
    );

    modport slave (
`ifdef MEM_BUS_WORD_EN
        output ReqWord,
`endif
        output ReqValid,
        input  ReqReady,
        output ReqAddr,
        output ReqWE,
        output ReqData,
        input  RspValid,
        input  RspData,
        input  MemAddress,
        input  MemDataOut,
        input  MemWE,
        input  MemOE,
        input  MemTick,
        output MemDataIn
    );

endinterface

// File: rtl/mem_bus_master.sv
// ----------------------------------------------------------------------------
// mem_bus_master
//   Initiator side of the Tick-strobed memory bus, between the 6502 core and
//   the MEMORY block. One byte access at a time: a request accepted on
//   ReqValid && ReqReady is registered onto the Mem* outputs, MemTick pulses
//   for one cycle, the master waits MEM_LATENCY cycles, captures MemDataIn and
//   pulses RspValid for one cycle. Sequence: IDLE -> ISSUE -> WAIT -> CAP.
//
//   Ports
//     Clock      in   single clock, everything on posedge
//     Reset_n    in   synchronous active-low reset
//     bus        mem_bus_master_if.master
//                  ReqValid/ReqReady/ReqAddr/ReqWE/ReqData[/ReqWord] request
//                  RspValid/RspData                                response
//                  MemAddress/MemDataOut/MemWE/MemOE/MemTick/MemDataIn MEMORY
//
//   Parameters
//     ADDR_W       address width, address arithmetic wraps modulo 2^ADDR_W
//     DATA_W       byte width
//     MEM_LATENCY  wait cycles between Tick and capture (>= 1)
//
//   Configuration macro MEM_BUS_WORD_EN: a read with ReqWord=1 performs two
//   byte accesses (A, then A+1) and returns {byte@A+1, byte@A} with a single
//   RspValid. Without it every access is one byte and RspData hi is zero.
// ----------------------------------------------------------------------------
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = MEM_BUS_ADDR_W,
    parameter int DATA_W      = MEM_BUS_DATA_W,
    parameter int MEM_LATENCY = MEM_BUS_LATENCY
) (
    input  logic             Clock,
    input  logic             Reset_n,
    mem_bus_master_if.master bus
);

    localparam int               CNT_W    = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    mem_bus_state_e      state;
    mem_bus_state_e      state_nxt;

    logic [CNT_W-1:0]    wait_cnt;

    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_dout_q;
    logic                mem_we_q;
    logic                mem_oe_q;
    logic                rsp_valid_q;
    logic [2*DATA_W-1:0] rsp_data_q;

    // Decoded per-cycle controls from the FSM
    logic                req_ready;
    logic                mem_tick;
    logic                accept;
    logic                cnt_inc;
    logic                rsp_fire;
    logic                next_byte;
    logic                more_bytes;

`ifdef MEM_BUS_WORD_EN
    logic                word_req_q;   // accepted access is a word read
    logic                hi_phase_q;   // second byte of a word read in flight
    logic [DATA_W-1:0]   lo_byte_q;    // first byte captured for a word read

    assign more_bytes = word_req_q && !hi_phase_q;
`else
    assign more_bytes = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    // NOTE: every signal gets its default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_tick  = 1'b0;
        accept    = 1'b0;
        cnt_inc   = 1'b0;
        rsp_fire  = 1'b0;
        next_byte = 1'b0;

        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.ReqValid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_tick  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_inc = 1'b1;
                if (wait_cnt == CNT_LAST) begin
                    state_nxt = CAP;
                end
            end
            CAP: begin
                // Word reads go round again for the byte at A+1 before
                // the single response is issued.
                if (more_bytes) begin
                    next_byte = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: wait counter, Mem* output registers, response registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            wait_cnt    <= '0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef MEM_BUS_WORD_EN
            word_req_q  <= 1'b0;
            hi_phase_q  <= 1'b0;
            lo_byte_q   <= '0;
`endif
        end else begin
            rsp_valid_q <= rsp_fire;

            // Counter self-clears on its last WAIT cycle so a second
            // byte of a word read starts again from zero.
            if (cnt_inc) begin
                wait_cnt <= (wait_cnt == CNT_LAST) ? '0 : wait_cnt + 1'b1;
            end

            // Mem* are loaded only on accept and hold between accesses.
            if (accept) begin
                mem_addr_q <= bus.ReqAddr;
                mem_dout_q <= bus.ReqData;
                mem_we_q   <= bus.ReqWE;
                mem_oe_q   <= !bus.ReqWE;
`ifdef MEM_BUS_WORD_EN
                word_req_q <= bus.ReqWord && !bus.ReqWE;
                hi_phase_q <= 1'b0;
`endif
            end

`ifdef MEM_BUS_WORD_EN
            if (next_byte) begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
                lo_byte_q  <= bus.MemDataIn;
                hi_phase_q <= 1'b1;
            end

            // Writes leave RspData untouched.
            if (rsp_fire && mem_oe_q) begin
                rsp_data_q <= hi_phase_q ? {bus.MemDataIn, lo_byte_q}
                                         : {{DATA_W{1'b0}}, bus.MemDataIn};
            end
`else
            if (rsp_fire && mem_oe_q) begin
                rsp_data_q <= {{DATA_W{1'b0}}, bus.MemDataIn};
            end
`endif
        end
    end

    assign bus.ReqReady   = req_ready;
    assign bus.MemTick    = mem_tick;
    assign bus.MemAddress = mem_addr_q;
    assign bus.MemDataOut = mem_dout_q;
    assign bus.MemWE      = mem_we_q;
    assign bus.MemOE      = mem_oe_q;
    assign bus.RspValid   = rsp_valid_q;
    assign bus.RspData    = rsp_data_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_master
//   Bench for mem_bus_master wired to a behavioural MEMORY with a preload.
//   A cycle monitor predicts every output from the bus rules (ready while no
//   access is outstanding, Tick one cycle after accept, response a fixed
//   number of cycles later, Mem* holding the accepted request) and a
//   reference byte array holds the expected memory contents.
//   Configuration macro MEM_BUS_WORD_EN enables the word-read tests.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int LAT      = MEM_BUS_LATENCY;
    localparam int BYTE_RSP = 3 + LAT;          // accept n -> RspValid n+5
    localparam int WORD_RSP = 5 + 2 * LAT;      // accept n -> RspValid n+9
`ifdef MEM_BUS_WORD_EN
    localparam bit WORD_EN  = 1'b1;
`else
    localparam bit WORD_EN  = 1'b0;
`endif

    logic Clock   = 1'b0;
    logic Reset_n = 1'b0;
    logic req_word = 1'b0;

    mem_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_BUS_WORD_EN
    assign bus.ReqWord = req_word;
`endif

    mem_bus_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_LATENCY (LAT)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus.master)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // MEMORY stand-in: write on Tick, read data valid LAT+1 cycles after
    // the Tick cycle; garbage on DataOut otherwise.
    // ------------------------------------------------------------------
    logic [7:0] mem_model [0:65535];
    logic [7:0] ref_mem   [0:65535];
    logic [7:0] pipe_d    [LAT];
    bit         pipe_v    [LAT];

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pipe_d[i] = '0;
            pipe_v[i] = 1'b0;
        end
        bus.MemDataIn = 8'h00;
    end

    always @(posedge Clock) begin
        logic [7:0] out_d;
        bit         out_v;
        out_d = pipe_d[LAT-1];
        out_v = pipe_v[LAT-1];
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_d[k] = pipe_d[k-1];
            pipe_v[k] = pipe_v[k-1];
        end
        pipe_v[0] = 1'b0;
        if (bus.MemTick) begin
            if (bus.MemWE) mem_model[bus.MemAddress] = bus.MemDataOut;
            if (bus.MemOE) begin
                pipe_d[0] = mem_model[bus.MemAddress];
                pipe_v[0] = 1'b1;
            end
        end
        #1;
        bus.MemDataIn = out_v ? out_d : 8'($urandom);
    end

    // ------------------------------------------------------------------
    // Cycle monitor with reference model
    // ------------------------------------------------------------------
    bit          mon_en    = 1'b0;
    bit          pend      = 1'b0;
    int          rsp_cyc   = 0;
    int          tick1     = -100;
    int          tick2     = -100;
    bit          exp_word  = 1'b0;
    logic [15:0] exp_addr  = '0;
    logic        exp_we    = 1'b0;
    logic        exp_oe    = 1'b0;
    logic [7:0]  exp_dout  = '0;
    logic [15:0] pend_data = '0;
    logic [15:0] shown_rsp = '0;
    logic        prev_tick = 1'b0;

    int          acc_cycs [$];
    int          rsp_cycs [$];
    logic [15:0] rsp_vals [$];

    always @(negedge Clock) begin
        logic        busy;
        logic        rsp_now;
        logic [15:0] a1;
        if (mon_en) begin
            if (pend && exp_word && cyc == tick2) exp_addr = exp_addr + 16'd1;
            busy    = pend && (cyc < rsp_cyc);
            rsp_now = pend && (cyc == rsp_cyc);
            check("req_ready",  bus.ReqReady, !busy);
            check("mem_tick",   bus.MemTick, pend && (cyc == tick1 || cyc == tick2));
            check("tick_twice", bus.MemTick & prev_tick, 0);
            check("mem_addr",   bus.MemAddress, exp_addr);
            check("mem_we",     bus.MemWE, exp_we);
            check("mem_oe",     bus.MemOE, exp_oe);
            check("mem_dout",   bus.MemDataOut, exp_dout);
            check("rsp_valid",  bus.RspValid, rsp_now);
            if (rsp_now) begin
                shown_rsp = pend_data;
                pend      = 1'b0;
            end
            check("rsp_data",   bus.RspData, shown_rsp);
            if (bus.RspValid === 1'b1) begin
                rsp_cycs.push_back(cyc);
                rsp_vals.push_back(bus.RspData);
            end
            prev_tick = bus.MemTick;
        end

        if (Reset_n === 1'b0) begin
            pend      = 1'b0;
            exp_addr  = '0;
            exp_we    = 1'b0;
            exp_oe    = 1'b0;
            exp_dout  = '0;
            shown_rsp = '0;
            prev_tick = 1'b0;
            mon_en    = 1'b1;
        end else if (mon_en && bus.ReqValid && bus.ReqReady) begin
            acc_cycs.push_back(cyc);
            exp_addr = bus.ReqAddr;
            exp_we   = bus.ReqWE;
            exp_oe   = !bus.ReqWE;
            exp_dout = bus.ReqData;
            exp_word = WORD_EN && req_word && !bus.ReqWE;
            tick1    = cyc + 1;
            tick2    = exp_word ? cyc + 3 + LAT : -100;
            rsp_cyc  = cyc + (exp_word ? WORD_RSP : BYTE_RSP);
            pend     = 1'b1;
            a1       = bus.ReqAddr + 16'd1;
            if (bus.ReqWE) begin
                ref_mem[bus.ReqAddr] = bus.ReqData;
                pend_data = shown_rsp;
            end else if (exp_word) begin
                pend_data = {ref_mem[a1], ref_mem[bus.ReqAddr]};
            end else begin
                pend_data = {8'h00, ref_mem[bus.ReqAddr]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Requester tasks (called at posedge+1)
    // ------------------------------------------------------------------
    task automatic send(input logic [15:0] a, input logic we, input logic [7:0] d,
                        input logic wd, input bit keep);
        bit ok;
        ok = 1'b0;
        bus.ReqValid = 1'b1;
        bus.ReqAddr  = a;
        bus.ReqWE    = we;
        bus.ReqData  = d;
        req_word     = wd;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (bus.ReqReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", ok, 1);
        @(posedge Clock);
        #1;
        if (!keep) bus.ReqValid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!pend) begin
                ok = 1'b1;
                break;
            end
            @(posedge Clock);
            #1;
        end
        check("rsp_timeout", ok, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] ra;
        logic [7:0]  rd;
        logic        rwe;
        logic        rwd;
        bit          rkeep;
        int          n_rsp;

        for (int i = 0; i < 65536; i++) begin
            mem_model[i] = 8'($urandom);
            ref_mem[i]   = mem_model[i];
        end
        mem_model[16'h0037] = 8'hDD;  mem_model[16'h0107] = 8'hAA;
        mem_model[16'h0110] = 8'hBB;  mem_model[16'h0304] = 8'hFF;
        mem_model[16'h01F7] = 8'h77;  mem_model[16'h001E] = 8'hFC;
        mem_model[16'h001F] = 8'h02;  mem_model[16'h0000] = 8'hA2;
        mem_model[16'hFFFF] = 8'h5C;
        ref_mem[16'h0037] = 8'hDD;    ref_mem[16'h0107] = 8'hAA;
        ref_mem[16'h0110] = 8'hBB;    ref_mem[16'h0304] = 8'hFF;
        ref_mem[16'h01F7] = 8'h77;    ref_mem[16'h001E] = 8'hFC;
        ref_mem[16'h001F] = 8'h02;    ref_mem[16'h0000] = 8'hA2;
        ref_mem[16'hFFFF] = 8'h5C;

        bus.ReqValid = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqWE    = 1'b0;
        bus.ReqData  = '0;
        Reset_n      = 1'b0;
        idle_cycles(3);
        Reset_n = 1'b1;

        // Reset state
        check("rst_req_ready", bus.ReqReady, 1);
        check("rst_rsp_valid", bus.RspValid, 0);
        check("rst_rsp_data",  bus.RspData, 16'h0000);
        check("rst_mem_addr",  bus.MemAddress, 16'h0000);
        check("rst_mem_tick",  bus.MemTick, 0);
        check("rst_mem_oe",    bus.MemOE, 0);
        idle_cycles(2);

        // Read $0037
        send(16'h0037, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rd37_tick", bus.MemTick, 1);
        check("rd37_oe",   bus.MemOE, 1);
        wait_done();
        check("rd37_data", rsp_vals[$], 16'h00DD);
        check("rd37_lat",  rsp_cycs[$] - acc_cycs[$], 5);

        // Write $AB to $0200, then read it back
        send(16'h0200, 1'b1, 8'hAB, 1'b0, 1'b0);
        check("wr200_oe", bus.MemOE, 0);
        wait_done();
        check("wr200_lat",  rsp_cycs[$] - acc_cycs[$], 5);
        check("wr200_data", rsp_vals[$], 16'h00DD);
        send(16'h0200, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_done();
        check("rd200_data", rsp_vals[$], 16'h00AB);

        // Back-to-back reads with ReqValid held
        send(16'h0107, 1'b0, 8'h00, 1'b0, 1'b1);
        send(16'h0110, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_done();
        check("b2b_first",  rsp_vals[$-1], 16'h00AA);
        check("b2b_second", rsp_vals[$], 16'h00BB);
        check("b2b_gap",    rsp_cycs[$] - rsp_cycs[$-1], 5);
        check("b2b_accept", acc_cycs[$], rsp_cycs[$-1]);

        // Reset in the cycle after MemTick of a read
        n_rsp = rsp_cycs.size();
        send(16'h01F7, 1'b0, 8'h00, 1'b0, 1'b0);
        idle_cycles(1);
        Reset_n = 1'b0;
        idle_cycles(1);
        Reset_n = 1'b1;
        check("abort_rsp_valid", bus.RspValid, 0);
        check("abort_req_ready", bus.ReqReady, 1);
        check("abort_mem_addr",  bus.MemAddress, 16'h0000);
        check("abort_mem_oe",    bus.MemOE, 0);
        check("abort_rsp_data",  bus.RspData, 16'h0000);
        idle_cycles(8);
        check("abort_no_rsp", rsp_cycs.size(), n_rsp);
        send(16'h0304, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_done();
        check("rd304_data", rsp_vals[$], 16'h00FF);

`ifdef MEM_BUS_WORD_EN
        // Word reads, including address wrap
        send(16'h001E, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_done();
        check("w1e_data", rsp_vals[$], 16'h02FC);
        check("w1e_lat",  rsp_cycs[$] - acc_cycs[$], 9);
        send(16'hFFFF, 1'b0, 8'h00, 1'b1, 1'b0);
        idle_cycles(4);
        check("wffff_tick2", bus.MemTick, 1);
        check("wffff_addr2", bus.MemAddress, 16'h0000);
        wait_done();
        check("wffff_data", rsp_vals[$], 16'hA25C);
        // Word flag on a write is a plain byte write
        send(16'h0500, 1'b1, 8'h3C, 1'b1, 1'b0);
        wait_done();
        check("wwr_lat", rsp_cycs[$] - acc_cycs[$], 5);
`endif

        // Randomized accesses over a small window plus the top of memory
        for (int i = 0; i < 60; i++) begin
            ra    = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                : 16'h0400 + 16'($urandom_range(0, 15));
            rd    = 8'($urandom);
            rwe   = 1'($urandom_range(0, 1));
            rwd   = 1'($urandom_range(0, 1));
            rkeep = (i != 59) && ($urandom_range(0, 1) == 1);
            send(ra, rwe, rd, rwd, rkeep);
            if (!rkeep) wait_done();
        end
        wait_done();
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
